// File: rtl/servant_spi_flash_if.sv
// servant_spi_flash_if: Wishbone flash-window bus between the address mux and the SPI flash responder
//  master: drives adr/dat/sel/we/cyc, receives rdt/ack
//  slave : receives adr/dat/sel/we/cyc, drives rdt/ack
interface servant_spi_flash_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_spi_flash.sv
// servant_spi_flash: Wishbone responder that turns each CPU read into an SPI-flash read burst
//  i_clk, i_rst   : clock, synchronous active-high reset
//  io_wb          : Wishbone slave (adr[23:2] used; dat/sel ignored; single-cycle ack)
//  o_spi_sck      : SPI clock, mode 0, CLK_DIV clocks per half period
//  o_spi_cs_n     : flash chip select, active low
//  o_spi_mosi     : command + address, MSB first
//  i_spi_miso     : flash read data
//  SPI_FAST_READ_EN: when defined, issue 0x0B with 8 dummy bits instead of plain 0x03
module servant_spi_flash #(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  servant_spi_flash_if.slave io_wb,
  output logic               o_spi_sck,
  output logic               o_spi_cs_n,
  output logic               o_spi_mosi,
  input  logic               i_spi_miso
);
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         N   = 72;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         N   = 64;
`endif
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(2 * CLK_DIV + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, DONE, GAP, WACK} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [GW-1:0] r_gap;
  logic [6:0]    r_bit;
  logic [31:0]   r_sr, r_in, r_rdt;
  logic          r_ack, r_sck, r_cs_n, r_mosi;
  logic [23:0]   w_addr;
  logic [31:0]   w_word;
  logic          w_half_end, w_last, w_gap_end, w_start, w_unused;
  assign w_addr     = FLASH_BASE + {io_wb.adr[23:2], 2'b00};
  assign w_word     = {CMD, w_addr};
  assign w_half_end = r_div == DW'(CLK_DIV - 1);
  assign w_last     = r_bit == 7'(N - 1);
  assign w_gap_end  = r_gap == GW'(2 * CLK_DIV - 1);
  assign w_start    = r_state == IDLE && io_wb.cyc && !io_wb.we;
  assign w_unused   = ^{io_wb.dat, io_wb.sel, io_wb.adr[31:24], io_wb.adr[1:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !io_wb.cyc ? IDLE : io_wb.we ? WACK : SHIFT;
      SHIFT:   w_next = !io_wb.cyc ? GAP : (w_half_end && r_sck && w_last) ? DONE : SHIFT;
      DONE:    w_next = GAP;
      GAP:     w_next = w_gap_end ? IDLE : GAP;
      WACK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) r_state <= i_rst ? IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack  <= 1'b0;
      r_rdt  <= '0;
      r_sck  <= 1'b0;
      r_cs_n <= 1'b1;
      r_mosi <= 1'b0;
      r_div  <= '0;
      r_gap  <= '0;
      r_bit  <= '0;
      r_sr   <= '0;
      r_in   <= '0;
    end else begin
      r_ack <= r_state == WACK || r_state == DONE;
      r_div <= (r_state == SHIFT && !w_half_end) ? r_div + 1'b1 : '0;
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (w_start) begin
        r_cs_n <= 1'b0;
        r_sck  <= 1'b0;
        r_mosi <= w_word[31];
        r_sr   <= {w_word[30:0], 1'b0};
        r_bit  <= '0;
      end
      if (r_state == SHIFT) begin
        if (!io_wb.cyc) begin
          r_cs_n <= 1'b1;
          r_sck  <= 1'b0;
          r_mosi <= 1'b0;
        end else if (w_half_end) begin
          r_sck <= !r_sck;
          // Rising edge captures MISO; the register keeps only the last 32 bits, so dummy bits fall out.
          if (!r_sck) r_in <= {r_in[30:0], i_spi_miso};
          else if (w_last) r_cs_n <= 1'b1;
          else begin
            r_bit  <= r_bit + 1'b1;
            r_mosi <= r_sr[31];
            r_sr   <= {r_sr[30:0], 1'b0};
          end
        end
      end
      // First received byte is the lowest address, so bytes are swapped into little-endian order.
      if (r_state == DONE) r_rdt <= {r_in[7:0], r_in[15:8], r_in[23:16], r_in[31:24]};
    end
  end
  assign io_wb.rdt  = r_rdt;
  assign io_wb.ack  = r_ack;
  assign o_spi_sck  = r_sck;
  assign o_spi_cs_n = r_cs_n;
  assign o_spi_mosi = r_mosi;
endmodule

// File: tb/tb_servant_spi_flash.sv
// tb_servant_spi_flash: randomized self-checking bench for servant_spi_flash against a behavioural flash model
module tb_servant_spi_flash;
`ifdef SPI_FAST_READ_EN
  localparam int         NB  = 72;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         NB  = 64;
  localparam logic [7:0] CMD = 8'h03;
`endif
  localparam int DUM = NB - 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] adr [2], dat [2], rdt [2], seen [2], last_exp [2];
  logic we [2], cyc [2], ack [2], sck [2], cs_n [2], mosi [2];
  int mb [2];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic int cdv(input int d);
    return d != 0 ? 1 : 2;
  endfunction
  function automatic int lat(input int d);
    return NB * 2 * cdv(d) + 1;
  endfunction
  function automatic logic [23:0] fa(input int d, input logic [31:0] a);
    return (d != 0 ? 24'h100000 : 24'h000000) + {a[23:2], 2'b00};
  endfunction
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hEF;
      24'h000011: return 8'hBE;
      24'h000012: return 8'hAD;
      24'h000013: return 8'hDE;
      default:    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction
  function automatic logic fbit(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = fbyte(a + 24'(k / 8));
    return b[3'(7 - k % 8)];
  endfunction
  function automatic logic [31:0] exp_rdt(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_d
    servant_spi_flash_if wb ();
    logic miso = 1'b0;
    logic [31:0] w = '0;
    int cnt = 0;
    int bad = 0;
    assign wb.adr = adr[g];
    assign wb.dat = dat[g];
    assign wb.sel = 4'hF;
    assign wb.we  = we[g];
    assign wb.cyc = cyc[g];
    assign rdt[g] = wb.rdt;
    assign ack[g] = wb.ack;
    assign seen[g] = w;
    assign mb[g] = bad;
    servant_spi_flash #(.CLK_DIV(g != 0 ? 1 : 2), .FLASH_BASE(g != 0 ? 24'h100000 : 24'h000000)) dut (
      .i_clk(clk), .i_rst(rst), .io_wb(wb.slave),
      .o_spi_sck(sck[g]), .o_spi_cs_n(cs_n[g]), .o_spi_mosi(mosi[g]), .i_spi_miso(miso)
    );
    // flash side: command/address captured on rising sck, data driven on falling sck
    always @(negedge cs_n[g] or posedge sck[g]) begin
      if (sck[g] !== 1'b1) cnt = 0;
      else begin
        if (cnt < 32) w = {w[30:0], mosi[g]};
        else if (mosi[g] !== 1'b0) bad++;
        cnt++;
      end
    end
    always @(negedge sck[g]) miso = (cnt >= 32 + DUM) ? fbit(w[23:0], cnt - 32 - DUM) : 1'($urandom);
  end
  task automatic rd_txn(input int d, input logic [31:0] a, input int drop, input bit b2b,
                        output int s, output int at, output int an, output logic ca, output logic cd);
    adr[d] = a; we[d] = 1'b0; dat[d] = $urandom; cyc[d] = 1'b1;
    s = -1; at = -1; an = 0; ca = 1'b0; cd = 1'b0;
    for (int t = 0; t < lat(d) + 6 * cdv(d) + 8; t++) begin
      @(posedge clk); #1;
      if (s < 0 && cs_n[d] === 1'b0) s = t;
      if (ack[d] === 1'b1) begin
        an++;
        if (at < 0) begin at = t; ca = cs_n[d]; end
        cyc[d] = 1'b0;
        if (b2b) break;
      end
      if (t == drop) cyc[d] = 1'b0;
      if (drop >= 0 && t == drop + 1) cd = cs_n[d] & ~sck[d];
    end
    cyc[d] = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack[d], rdt[d], sck[d], cs_n[d], mosi[d]} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_state d%0d: got ack=%b rdt=%h sck=%b cs_n=%b mosi=%b want 0 0 0 1 0", d, ack[d], rdt[d], sck[d], cs_n[d], mosi[d]);
      end
      last_exp[d] = 32'h0;
    end
    rst = 1'b0;
  endtask
  task automatic test_read();
    int s, at, an;
    logic ca, cd;
    rd_txn(0, 32'hC000_0010, -1, 1'b0, s, at, an, ca, cd);
    checks++; if (s !== 0) begin fails++; $display("FAIL read_cs_fall: got %0d want 0", s); end
    checks++; if (at - s !== lat(0)) begin fails++; $display("FAIL read_latency: got %0d want %0d", at - s, lat(0)); end
    checks++; if (ca !== 1'b1) begin fails++; $display("FAIL read_cs_in_ack: got %b want 1", ca); end
    checks++; if (an !== 1) begin fails++; $display("FAIL read_ack_cycles: got %0d want 1", an); end
    checks++; if (rdt[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data: got %h want deadbeef", rdt[0]); end
    checks++; if (seen[0] !== {CMD, 24'h000010}) begin fails++; $display("FAIL read_mosi: got %h want %h", seen[0], {CMD, 24'h000010}); end
    last_exp[0] = 32'hDEADBEEF;
  endtask
  task automatic test_write();
    int at, an;
    bit cl;
    at = -1; an = 0; cl = 1'b0;
    adr[0] = 32'hC000_0000; dat[0] = 32'h1234_5678; we[0] = 1'b1; cyc[0] = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (cs_n[0] !== 1'b1) cl = 1'b1;
      if (ack[0] === 1'b1) begin an++; if (at < 0) at = t; cyc[0] = 1'b0; end
    end
    we[0] = 1'b0;
    checks++; if (at !== 1) begin fails++; $display("FAIL write_ack_cycle: got %0d want 1", at); end
    checks++; if (an !== 1) begin fails++; $display("FAIL write_ack_cycles: got %0d want 1", an); end
    checks++; if (cl !== 1'b0) begin fails++; $display("FAIL write_cs_low: got %b want 0", cl); end
    checks++; if (rdt[0] !== last_exp[0]) begin fails++; $display("FAIL write_rdt_kept: got %h want %h", rdt[0], last_exp[0]); end
  endtask
  task automatic test_reset_midburst();
    int an;
    an = 0;
    adr[0] = 32'hC000_1230; we[0] = 1'b0; cyc[0] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (cs_n[0] !== 1'b0) begin fails++; $display("FAIL midburst_cs: got %b want 0", cs_n[0]); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({cs_n[0], sck[0], ack[0], rdt[0]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        fails++;
        $display("FAIL midburst_reset c%0d: got cs_n=%b sck=%b ack=%b rdt=%h want 1 0 0 0", i, cs_n[0], sck[0], ack[0], rdt[0]);
      end
    end
    cyc[0] = 1'b0; rst = 1'b0; last_exp[0] = 32'h0;
    for (int t = 0; t < lat(0) + 10; t++) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1 || ack[1] === 1'b1) an++;
    end
    checks++; if (an !== 0) begin fails++; $display("FAIL midburst_no_ack: got %0d want 0", an); end
  endtask
  task automatic test_back_to_back();
    int s, at, an;
    logic ca, cd;
    logic [31:0] a1, a2;
    logic [23:0] f1, f2;
    for (int d = 0; d < 2; d++) begin
      a1 = d != 0 ? 32'hC00F_FFFC : {8'hC0, 24'($urandom)};
      a2 = d != 0 ? 32'hC0FF_FFFC : {8'hC0, 24'($urandom)};
      f1 = d != 0 ? 24'h1FFFFC : fa(d, a1);
      f2 = d != 0 ? 24'h0FFFFC : fa(d, a2);
      rd_txn(d, a1, -1, 1'b1, s, at, an, ca, cd);
      checks++; if (seen[d] !== {CMD, f1}) begin fails++; $display("FAIL b2b_mosi1 d%0d: got %h want %h", d, seen[d], {CMD, f1}); end
      checks++; if (rdt[d] !== exp_rdt(f1)) begin fails++; $display("FAIL b2b_data1 d%0d: got %h want %h", d, rdt[d], exp_rdt(f1)); end
      checks++; if (at - s !== lat(d)) begin fails++; $display("FAIL b2b_latency1 d%0d: got %0d want %0d", d, at - s, lat(d)); end
      rd_txn(d, a2, -1, 1'b0, s, at, an, ca, cd);
      checks++; if (s < 0 || s + 2 < 2 * cdv(d)) begin fails++; $display("FAIL b2b_gap d%0d: got %0d want >=%0d", d, s + 2, 2 * cdv(d)); end
      checks++; if (at - s !== lat(d)) begin fails++; $display("FAIL b2b_latency2 d%0d: got %0d want %0d", d, at - s, lat(d)); end
      checks++; if (seen[d] !== {CMD, f2}) begin fails++; $display("FAIL b2b_mosi2 d%0d: got %h want %h", d, seen[d], {CMD, f2}); end
      checks++; if (rdt[d] !== exp_rdt(f2)) begin fails++; $display("FAIL b2b_data2 d%0d: got %h want %h", d, rdt[d], exp_rdt(f2)); end
      last_exp[d] = exp_rdt(f2);
    end
  endtask
  task automatic test_abort();
    int s, at, an;
    logic ca, cd;
    logic [31:0] a;
    a = {8'hC0, 24'($urandom)};
    rd_txn(0, a, -1, 1'b0, s, at, an, ca, cd);
    checks++; if (rdt[0] !== exp_rdt(fa(0, a))) begin fails++; $display("FAIL abort_pre_data: got %h want %h", rdt[0], exp_rdt(fa(0, a))); end
    last_exp[0] = exp_rdt(fa(0, a));
    rd_txn(0, {8'hC0, 24'($urandom)}, 100, 1'b0, s, at, an, ca, cd);
    checks++; if (s !== 0) begin fails++; $display("FAIL abort_cs_fall: got %0d want 0", s); end
    checks++; if (cd !== 1'b1) begin fails++; $display("FAIL abort_cs_high: got %b want 1", cd); end
    checks++; if (an !== 0) begin fails++; $display("FAIL abort_no_ack: got %0d want 0", an); end
    checks++; if (rdt[0] !== last_exp[0]) begin fails++; $display("FAIL abort_rdt_kept: got %h want %h", rdt[0], last_exp[0]); end
    a = {8'hC0, 24'($urandom)};
    rd_txn(0, a, -1, 1'b0, s, at, an, ca, cd);
    checks++; if (rdt[0] !== exp_rdt(fa(0, a))) begin fails++; $display("FAIL abort_post_data: got %h want %h", rdt[0], exp_rdt(fa(0, a))); end
    checks++; if (at - s !== lat(0)) begin fails++; $display("FAIL abort_post_latency: got %0d want %0d", at - s, lat(0)); end
    last_exp[0] = exp_rdt(fa(0, a));
  endtask
  task automatic test_random();
    int s, at, an, d;
    logic ca, cd;
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 1);
      a = {3'b110, 5'($urandom), 24'($urandom)};
      rd_txn(d, a, -1, 1'b0, s, at, an, ca, cd);
      checks++; if (seen[d] !== {CMD, fa(d, a)}) begin fails++; $display("FAIL rand_mosi %0d: got %h want %h", i, seen[d], {CMD, fa(d, a)}); end
      checks++; if (rdt[d] !== exp_rdt(fa(d, a))) begin fails++; $display("FAIL rand_data %0d: got %h want %h", i, rdt[d], exp_rdt(fa(d, a))); end
      checks++; if (at - s !== lat(d) || an !== 1) begin fails++; $display("FAIL rand_ack %0d: got lat=%0d n=%0d want lat=%0d n=1", i, at - s, an, lat(d)); end
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (mb[k] !== 0) begin fails++; $display("FAIL mosi_data_phase d%0d: got %0d nonzero bits want 0", k, mb[k]); end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; dat[i] = '0; we[i] = 1'b0; cyc[i] = 1'b0;
    end
    test_reset();
    test_read();
    test_write();
    test_reset_midburst();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
